// File: rtl/shift_add_mul.sv
// Sequential shift-and-add multiplier with unsigned and two's-complement modes.
// Defining SHIFT_ADD_MUL_EARLY_EN ends RUN as soon as no multiplier bits remain.
module shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [PW-1:0]   mcand_r;
  logic [PW-1:0]   acc_r;
  logic [PW-1:0]   product_r;
  logic [PW-1:0]   term_s;
  logic [PW-1:0]   acc_nxt_s;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] mplier_shift_s;
  logic [5:0]      cnt_r;
  logic            sgn_r;
  logic            busy_r;
  logic            done_r;
  logic            last_s;
  logic            finish_s;
  logic            accept_s;

  // One multiplier bit per RUN cycle; the sign bit weight is negative in signed mode.
  always_comb begin
    mplier_shift_s = mplier_r >> 1;
    last_s         = (cnt_r == 6'(WIDTH - 1));
    if (sgn_r && last_s) begin
      term_s = {PW{1'b0}} - mcand_r;
    end else begin
      term_s = mcand_r;
    end
    if (mplier_r[0]) begin
      acc_nxt_s = acc_r + term_s;
    end else begin
      acc_nxt_s = acc_r;
    end
`ifdef SHIFT_ADD_MUL_EARLY_EN
    finish_s = last_s || (mplier_shift_s == {WIDTH{1'b0}});
`else
    finish_s = last_s;
`endif
    accept_s = start && (state_r != RUN);
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (finish_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register with registered status flags decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Operand capture, iteration and result load; product is untouched during RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r   <= {PW{1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      acc_r     <= {PW{1'b0}};
      product_r <= {PW{1'b0}};
      cnt_r     <= 6'd0;
      sgn_r     <= 1'b0;
    end else if (accept_s) begin
      sgn_r    <= sgn;
      mcand_r  <= sgn ? {{WIDTH{in1[WIDTH-1]}}, in1} : {{WIDTH{1'b0}}, in1};
      mplier_r <= in2;
      acc_r    <= {PW{1'b0}};
      cnt_r    <= 6'd0;
    end else if (state_r == RUN) begin
      acc_r    <= acc_nxt_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_shift_s;
      cnt_r    <= cnt_r + 6'd1;
      if (finish_s) begin
        product_r <= acc_nxt_s;
      end else begin
        product_r <= product_r;
      end
    end else begin
      acc_r <= acc_r;
    end
  end

  assign product = product_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule
